// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache line fill engine.
//   fetch_cmd_e : encoding of the fetch command from the read controller
//   lf_state_t  : fill engine state encoding
//   LF_*        : default geometry and the derived tag/offset widths
package cache_pkg;

    localparam int LF_ADDR_WIDTH = 32;
    localparam int LF_LIST_DEPTH = 4;
    localparam int LF_DATA_WIDTH = 32;
    localparam int LF_LIST_WIDTH = 32;
    localparam int LF_TAG_W      = $clog2(LF_LIST_DEPTH);
    localparam int LF_OFF_W      = $clog2(LF_LIST_WIDTH);

    typedef enum logic [1:0] {
        FETCH_NOP     = 2'b00,
        FETCH_FILL    = 2'b01,
        FETCH_WB_FILL = 2'b10
    } fetch_cmd_e;

    typedef enum logic [2:0] {
        LF_IDLE    = 3'd0,
        LF_WB_RD   = 3'd1,
        LF_WB_WAIT = 3'd2,
        LF_WB_WR   = 3'd3,
        LF_FL_REQ  = 3'd4,
        LF_FL_WAIT = 3'd5,
        LF_FL_WR   = 3'd6,
        LF_DONE    = 3'd7
    } lf_state_t;

endpackage

// File: rtl/line_fill_ctrl_if.sv
// Signal bundle between the line fill engine and its neighbours.
//   fetch_* : request/grant port from the read controller, done pulse back
//   mem_*   : cache data array read and write ports ({tag, word offset} addressing)
//   bus_*   : request/grant backing-memory bus with a separate read response
// Modports:
//   master : the fill engine itself
//   slave  : the surrounding read controller, data array and backing memory
interface line_fill_ctrl_if #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32
);
    localparam int tag_w = $clog2(list_depth);
    localparam int off_w = $clog2(list_width);

    logic                    fetch_req;
    logic                    fetch_gnt;
    logic [1:0]              fetch_cmd;
    logic [tag_w-1:0]        fetch_tag;
    logic [addr_width-1:0]   fetch_addr;
    logic [addr_width-1:0]   evict_addr;
    logic                    fetch_done;

    logic                    mem_ren;
    logic [tag_w+off_w-1:0]  mem_raddr;
    logic                    mem_rready;
    logic [data_width-1:0]   mem_rdata;
    logic                    mem_rdata_valid;
    logic                    mem_wen;
    logic [tag_w+off_w-1:0]  mem_waddr;
    logic [data_width-1:0]   mem_wdata;
    logic                    mem_wready;

    logic                    bus_req;
    logic                    bus_we;
    logic [addr_width-1:0]   bus_addr;
    logic [data_width-1:0]   bus_wdata;
    logic                    bus_gnt;
    logic                    bus_rvalid;
    logic [data_width-1:0]   bus_rdata;

    modport master (
        input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, evict_addr,
        input  mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output fetch_gnt, fetch_done,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        output bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output fetch_req, fetch_cmd, fetch_tag, fetch_addr, evict_addr,
        output mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  fetch_gnt, fetch_done,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata,
        input  bus_req, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/line_fill_ctrl.sv
// Cache line fetch engine. Takes one fetch request at a time from the read
// controller, optionally writes the victim line back to backing memory, then
// fills the target line word by word and pulses fetch_done.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   lf    : line_fill_ctrl_if.master (fetch port, data array ports, backing bus)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// LF_IDLE    | fetch_gnt high, waiting for fetch_req
// LF_WB_RD   | data-array read of victim word k requested
// LF_WB_WAIT | read accepted, waiting for mem_rdata_valid
// LF_WB_WR   | bus write of victim word k to evict line
// LF_FL_REQ  | bus read of fill word k requested
// LF_FL_WAIT | bus read granted, waiting for bus_rvalid
// LF_FL_WR   | data-array write of fill word k
// LF_DONE    | fetch_done pulse, back to idle next cycle
module line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int addr_width = LF_ADDR_WIDTH,
    parameter int list_depth = LF_LIST_DEPTH,
    parameter int data_width = LF_DATA_WIDTH,
    parameter int list_width = LF_LIST_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    line_fill_ctrl_if.master lf
);

    localparam int tag_w  = $clog2(list_depth);
    localparam int off_w  = $clog2(list_width);
    localparam int base_w = addr_width - off_w;
    localparam logic [off_w-1:0] last_k = off_w'(list_width - 1);

    lf_state_t               state;
    logic [tag_w-1:0]        tag_q;
    logic [base_w-1:0]       fill_base;
    logic [base_w-1:0]       evict_base;
    logic [off_w-1:0]        k;
    logic [off_w-1:0]        k_nxt;

    logic                    fetch_gnt_q;
    logic                    fetch_done_q;
    logic                    mem_ren_q;
    logic [tag_w+off_w-1:0]  mem_raddr_q;
    logic                    mem_wen_q;
    logic [tag_w+off_w-1:0]  mem_waddr_q;
    logic [data_width-1:0]   mem_wdata_q;
    logic                    bus_req_q;
    logic                    bus_we_q;
    logic [addr_width-1:0]   bus_addr_q;
    logic [data_width-1:0]   bus_wdata_q;

    assign k_nxt = k + off_w'(1);

    // All request outputs are registered and loaded on the transition into
    // the state that owns them, so they stay put until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LF_IDLE;
            tag_q        <= '0;
            fill_base    <= '0;
            evict_base   <= '0;
            k            <= '0;
            fetch_gnt_q  <= 1'b1;
            fetch_done_q <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_raddr_q  <= '0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            fetch_done_q <= 1'b0;
            case (state)
                LF_IDLE: begin
                    if (lf.fetch_req) begin
                        tag_q       <= lf.fetch_tag;
                        fill_base   <= lf.fetch_addr[addr_width-1:off_w];
                        evict_base  <= lf.evict_addr[addr_width-1:off_w];
                        k           <= '0;
                        fetch_gnt_q <= 1'b0;
                        case (lf.fetch_cmd)
                            FETCH_WB_FILL: begin
                                state       <= LF_WB_RD;
                                mem_ren_q   <= 1'b1;
                                mem_raddr_q <= {lf.fetch_tag, {off_w{1'b0}}};
                            end
                            FETCH_NOP: begin
                                state        <= LF_DONE;
                                fetch_done_q <= 1'b1;
                            end
                            default: begin
                                state      <= LF_FL_REQ;
                                bus_req_q  <= 1'b1;
                                bus_we_q   <= 1'b0;
                                bus_addr_q <= {lf.fetch_addr[addr_width-1:off_w], {off_w{1'b0}}};
                            end
                        endcase
                    end
                end
                LF_WB_RD: begin
                    if (lf.mem_rready) begin
                        mem_ren_q <= 1'b0;
                        // Zero-latency read data skips the wait state.
                        if (lf.mem_rdata_valid) begin
                            state       <= LF_WB_WR;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= 1'b1;
                            bus_addr_q  <= {evict_base, k};
                            bus_wdata_q <= lf.mem_rdata;
                        end else begin
                            state <= LF_WB_WAIT;
                        end
                    end
                end
                LF_WB_WAIT: begin
                    if (lf.mem_rdata_valid) begin
                        state       <= LF_WB_WR;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= {evict_base, k};
                        bus_wdata_q <= lf.mem_rdata;
                    end
                end
                LF_WB_WR: begin
                    if (lf.bus_gnt) begin
                        if (k == last_k) begin
                            // Straight into the first fill read; bus_req stays high.
                            k          <= '0;
                            state      <= LF_FL_REQ;
                            bus_we_q   <= 1'b0;
                            bus_addr_q <= {fill_base, {off_w{1'b0}}};
                        end else begin
                            k           <= k_nxt;
                            state       <= LF_WB_RD;
                            bus_req_q   <= 1'b0;
                            bus_we_q    <= 1'b0;
                            mem_ren_q   <= 1'b1;
                            mem_raddr_q <= {tag_q, k_nxt};
                        end
                    end
                end
                LF_FL_REQ: begin
                    if (lf.bus_gnt) begin
                        bus_req_q <= 1'b0;
                        if (lf.bus_rvalid) begin
                            state       <= LF_FL_WR;
                            mem_wen_q   <= 1'b1;
                            mem_waddr_q <= {tag_q, k};
                            mem_wdata_q <= lf.bus_rdata;
                        end else begin
                            state <= LF_FL_WAIT;
                        end
                    end
                end
                LF_FL_WAIT: begin
                    if (lf.bus_rvalid) begin
                        state       <= LF_FL_WR;
                        mem_wen_q   <= 1'b1;
                        mem_waddr_q <= {tag_q, k};
                        mem_wdata_q <= lf.bus_rdata;
                    end
                end
                LF_FL_WR: begin
                    if (lf.mem_wready) begin
                        mem_wen_q <= 1'b0;
                        if (k == last_k) begin
                            state        <= LF_DONE;
                            fetch_done_q <= 1'b1;
                        end else begin
                            k          <= k_nxt;
                            state      <= LF_FL_REQ;
                            bus_req_q  <= 1'b1;
                            bus_addr_q <= {fill_base, k_nxt};
                        end
                    end
                end
                LF_DONE: begin
                    state       <= LF_IDLE;
                    fetch_gnt_q <= 1'b1;
                end
                default: begin
                    state       <= LF_IDLE;
                    fetch_gnt_q <= 1'b1;
                end
            endcase
        end
    end

    assign lf.fetch_gnt  = fetch_gnt_q;
    assign lf.fetch_done = fetch_done_q;
    assign lf.mem_ren    = mem_ren_q;
    assign lf.mem_raddr  = mem_raddr_q;
    assign lf.mem_wen    = mem_wen_q;
    assign lf.mem_waddr  = mem_waddr_q;
    assign lf.mem_wdata  = mem_wdata_q;
    assign lf.bus_req    = bus_req_q;
    assign lf.bus_we     = bus_we_q;
    assign lf.bus_addr   = bus_addr_q;
    assign lf.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Directed bench for line_fill_ctrl: a vector table of fetch requests with
// hand-computed latencies and transfer counts, checked against logged bus and
// data-array traffic, plus reset-abort and back-to-back sequences.
module tb_line_fill_ctrl;
    import cache_pkg::*;

    localparam int addr_width = LF_ADDR_WIDTH;
    localparam int list_depth = LF_LIST_DEPTH;
    localparam int data_width = LF_DATA_WIDTH;
    localparam int list_width = LF_LIST_WIDTH;
    localparam int tag_w      = LF_TAG_W;
    localparam int off_w      = LF_OFF_W;
    localparam int ma_w       = tag_w + off_w;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_ctrl_if #(
        .addr_width(addr_width), .list_depth(list_depth),
        .data_width(data_width), .list_width(list_width)
    ) lf ();

    line_fill_ctrl #(
        .addr_width(addr_width), .list_depth(list_depth),
        .data_width(data_width), .list_width(list_width)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lf    (lf)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;
    typedef struct packed {
        logic [ma_w-1:0] a;
        logic [31:0]     d;
    } mw_t;
    typedef struct {
        logic [1:0]       cmd;
        logic [tag_w-1:0] tag;
        logic [31:0]      faddr;
        logic [31:0]      eaddr;
        bit               stall;
        int               lat;
        int               nwr;
        int               nrd;
    } vec_t;

    bus_t            bus_log[$], bus_exp[$];
    mw_t             mw_log[$], mw_exp[$];
    logic [ma_w-1:0] mr_log[$], mr_exp[$];
    logic [31:0]     arr[list_depth*list_width];
    logic [31:0]     exp_arr[list_depth*list_width];
    bit              arr_ok = 1'b0;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  gnt_low = 0;
    int  stable_err = 0;
    bit  stall_en = 1'b0;

    int          bg_dly = 0, rv_dly = 0, mr_dly = 0, mv_dly = 0, mw_dly = 0;
    bit          rd_pend = 1'b0, mrd_pend = 1'b0;
    logic [31:0] rd_data, mrd_data;
    bit          hb_v = 1'b0, hr_v = 1'b0, hw_v = 1'b0;
    logic [64:0] hb;
    logic [ma_w-1:0] hr;
    logic [ma_w+31:0] hw;

    function automatic int rnd();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    // Responders and monitors: decide handshakes on the falling edge for the
    // following rising edge, logging each transfer as it is accepted.
    always @(negedge clk) begin
        int d;
        cyc++;
        if (!arr_ok) begin
            for (int i = 0; i < list_depth*list_width; i++) arr[i] = 32'hA000_0000 | i;
            arr_ok = 1'b1;
        end
        if (!stall_en) begin
            bg_dly = 0; rv_dly = 0; mr_dly = 0; mv_dly = 0; mw_dly = 0;
        end
        lf.bus_gnt = 1'b0; lf.bus_rvalid = 1'b0; lf.bus_rdata = '0;
        lf.mem_rready = 1'b0; lf.mem_rdata_valid = 1'b0; lf.mem_rdata = '0; lf.mem_wready = 1'b0;
        if (!rst_n) begin
            rd_pend = 1'b0; mrd_pend = 1'b0; hb_v = 1'b0; hr_v = 1'b0; hw_v = 1'b0;
        end else begin
            if (lf.fetch_done) begin done_cnt++; done_cyc = cyc; end
            if (!lf.fetch_gnt) gnt_low++;

            if (hb_v && lf.bus_req && {lf.bus_we, lf.bus_addr, lf.bus_wdata} != hb) stable_err++;
            if (rd_pend) begin
                if (rv_dly == 0) begin lf.bus_rvalid = 1'b1; lf.bus_rdata = rd_data; rd_pend = 1'b0; end
                else rv_dly--;
            end else if (stall_en && !lf.bus_req && $urandom_range(0, 3) == 0) begin
                lf.bus_rvalid = 1'b1; lf.bus_rdata = 32'hDEAD_BEEF;
            end
            if (lf.bus_req) begin
                if (bg_dly == 0) begin
                    lf.bus_gnt = 1'b1;
                    bus_log.push_back({lf.bus_we, lf.bus_addr, lf.bus_we ? lf.bus_wdata : lf.bus_addr});
                    bg_dly = rnd();
                    if (!lf.bus_we) begin
                        d = rnd();
                        if (d == 0) begin lf.bus_rvalid = 1'b1; lf.bus_rdata = lf.bus_addr; end
                        else begin rd_pend = 1'b1; rv_dly = d - 1; rd_data = lf.bus_addr; end
                    end
                end else bg_dly--;
            end
            hb_v = lf.bus_req && !lf.bus_gnt;
            hb   = {lf.bus_we, lf.bus_addr, lf.bus_wdata};

            if (hr_v && lf.mem_ren && lf.mem_raddr != hr) stable_err++;
            if (mrd_pend) begin
                if (mv_dly == 0) begin lf.mem_rdata_valid = 1'b1; lf.mem_rdata = mrd_data; mrd_pend = 1'b0; end
                else mv_dly--;
            end else if (stall_en && !lf.mem_ren && $urandom_range(0, 3) == 0) begin
                lf.mem_rdata_valid = 1'b1; lf.mem_rdata = 32'hBAD0_BAD0;
            end
            if (lf.mem_ren) begin
                if (mr_dly == 0) begin
                    lf.mem_rready = 1'b1;
                    mr_log.push_back(lf.mem_raddr);
                    mr_dly = rnd();
                    d = rnd();
                    if (d == 0) begin lf.mem_rdata_valid = 1'b1; lf.mem_rdata = arr[lf.mem_raddr]; end
                    else begin mrd_pend = 1'b1; mv_dly = d - 1; mrd_data = arr[lf.mem_raddr]; end
                end else mr_dly--;
            end
            hr_v = lf.mem_ren && !lf.mem_rready;
            hr   = lf.mem_raddr;

            if (hw_v && lf.mem_wen && {lf.mem_waddr, lf.mem_wdata} != hw) stable_err++;
            if (lf.mem_wen) begin
                if (mw_dly == 0) begin
                    lf.mem_wready = 1'b1;
                    mw_log.push_back({lf.mem_waddr, lf.mem_wdata});
                    arr[lf.mem_waddr] = lf.mem_wdata;
                    mw_dly = rnd();
                end else mw_dly--;
            end
            hw_v = lf.mem_wen && !lf.mem_wready;
            hw   = {lf.mem_waddr, lf.mem_wdata};
        end
    end

    // Expected traffic for one request, from the bench's own array model.
    task automatic add_exp(input logic [1:0] cmd, input int tag, input logic [31:0] fa, input logic [31:0] ea);
        int base;
        logic [31:0] a;
        base = tag * list_width;
        if (cmd == 2'b10) begin
            for (int i = 0; i < list_width; i++) begin
                mr_exp.push_back(ma_w'(base + i));
                bus_exp.push_back({1'b1, (ea & ~32'(list_width - 1)) + 32'(i), exp_arr[base + i]});
            end
        end
        if (cmd != 2'b00) begin
            for (int i = 0; i < list_width; i++) begin
                a = (fa & ~32'(list_width - 1)) + 32'(i);
                bus_exp.push_back({1'b0, a, a});
                mw_exp.push_back({ma_w'(base + i), a});
                exp_arr[base + i] = a;
            end
        end
    endtask

    task automatic clear_all();
        bus_log.delete(); bus_exp.delete(); mw_log.delete(); mw_exp.delete();
        mr_log.delete(); mr_exp.delete();
        done_cnt = 0; gnt_low = 0; stable_err = 0;
    endtask

    task automatic do_req(input logic [1:0] cmd, input logic [tag_w-1:0] tag,
                          input logic [31:0] fa, input logic [31:0] ea, output int hs);
        int t;
        lf.fetch_cmd = cmd; lf.fetch_tag = tag; lf.fetch_addr = fa; lf.evict_addr = ea;
        lf.fetch_req = 1'b1;
        t = 0;
        while (!lf.fetch_gnt && t < 50) begin @(negedge clk); #1; t++; end
        hs = cyc;
        if (!lf.fetch_gnt) chk("grant_timeout", 0, 1);
        @(posedge clk); #1;
        lf.fetch_req = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 6000) begin @(negedge clk); #1; t++; end
        if (done_cnt < n) chk("done_timeout", done_cnt, n);
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic check_logs(input string nm);
        int bad;
        chk({nm, " bus_len"}, bus_log.size(), bus_exp.size());
        bad = -1;
        for (int i = 0; i < bus_log.size() && i < bus_exp.size(); i++)
            if (bad < 0 && bus_log[i] != bus_exp[i]) bad = i;
        chk({nm, " bus_first_bad_idx"}, bad, -1);
        chk({nm, " mem_rd_len"}, mr_log.size(), mr_exp.size());
        bad = -1;
        for (int i = 0; i < mr_log.size() && i < mr_exp.size(); i++)
            if (bad < 0 && mr_log[i] != mr_exp[i]) bad = i;
        chk({nm, " mem_rd_first_bad_idx"}, bad, -1);
        chk({nm, " mem_wr_len"}, mw_log.size(), mw_exp.size());
        bad = -1;
        for (int i = 0; i < mw_log.size() && i < mw_exp.size(); i++)
            if (bad < 0 && mw_log[i] != mw_exp[i]) bad = i;
        chk({nm, " mem_wr_first_bad_idx"}, bad, -1);
        chk({nm, " stable_err"}, stable_err, 0);
    endtask

    function automatic logic any_out();
        return |{lf.fetch_done, lf.mem_ren, lf.mem_raddr, lf.mem_wen, lf.mem_waddr, lf.mem_wdata,
                 lf.bus_req, lf.bus_we, lf.bus_addr, lf.bus_wdata};
    endfunction

    vec_t vecs[7];

    initial begin
        int hs, hs2, nwr, nrd, t;
        string nm;

        vecs[0] = '{2'b01, 2'd2, 32'h0000_0100, 32'h0,         1'b0,  65,  0, 32};
        vecs[1] = '{2'b10, 2'd1, 32'h0000_0300, 32'h0000_0200, 1'b0, 129, 32, 32};
        vecs[2] = '{2'b00, 2'd0, 32'h0000_0000, 32'h0,         1'b0,   1,  0,  0};
        vecs[3] = '{2'b11, 2'd3, 32'h0000_045F, 32'h0,         1'b0,  65,  0, 32};
        vecs[4] = '{2'b01, 2'd0, 32'h0000_1000, 32'h0,         1'b1,  -1,  0, 32};
        vecs[5] = '{2'b10, 2'd2, 32'h0000_05A0, 32'h0000_0100, 1'b1,  -1, 32, 32};
        vecs[6] = '{2'b10, 2'd3, 32'h0000_0700, 32'h0000_0440, 1'b0, 129, 32, 32};

        for (int i = 0; i < list_depth*list_width; i++) exp_arr[i] = 32'hA000_0000 | i;
        lf.fetch_req = 1'b0; lf.fetch_cmd = '0; lf.fetch_tag = '0;
        lf.fetch_addr = '0; lf.evict_addr = '0;

        @(negedge clk); #1;
        chk("reset fetch_gnt", lf.fetch_gnt, 1);
        chk("reset outputs", any_out(), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post-reset fetch_gnt", lf.fetch_gnt, 1);
        chk("post-reset outputs", any_out(), 0);

        for (int v = 0; v < 7; v++) begin
            nm = $sformatf("vec%0d", v);
            stall_en = vecs[v].stall;
            @(negedge clk); #1;
            clear_all();
            add_exp(vecs[v].cmd, int'(vecs[v].tag), vecs[v].faddr, vecs[v].eaddr);
            do_req(vecs[v].cmd, vecs[v].tag, vecs[v].faddr, vecs[v].eaddr, hs);
            wait_done(1);
            chk({nm, " done_cnt"}, done_cnt, 1);
            if (vecs[v].lat >= 0) chk({nm, " latency"}, done_cyc - hs, vecs[v].lat);
            chk({nm, " gnt_low_cycles"}, gnt_low, done_cyc - hs);
            nwr = 0; nrd = 0;
            foreach (bus_log[j]) if (bus_log[j].we) nwr++; else nrd++;
            chk({nm, " bus_writes"}, nwr, vecs[v].nwr);
            chk({nm, " bus_reads"}, nrd, vecs[v].nrd);
            check_logs(nm);
        end

        // Reset in the middle of a fill, at word 10.
        stall_en = 1'b0;
        @(negedge clk); #1;
        clear_all();
        do_req(2'b01, 2'd0, 32'h0000_0800, 32'h0, hs);
        t = 0;
        while (mw_log.size() < 10 && t < 200) begin @(negedge clk); #1; t++; end
        @(negedge clk); #1;
        chk("abort at word10 bus_addr", lf.bus_addr, 32'h0000_080A);
        rst_n = 1'b0;
        #1;
        chk("abort fetch_gnt", lf.fetch_gnt, 1);
        chk("abort outputs", any_out(), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("abort no done", done_cnt, 0);
        chk("abort gnt after release", lf.fetch_gnt, 1);
        for (int i = 0; i < mw_log.size(); i++) exp_arr[i] = 32'h0000_0800 + 32'(i);

        clear_all();
        add_exp(2'b01, 0, 32'h0000_0900, 32'h0);
        do_req(2'b01, 2'd0, 32'h0000_0900, 32'h0, hs);
        wait_done(1);
        chk("restart done_cnt", done_cnt, 1);
        chk("restart latency", done_cyc - hs, 65);
        check_logs("restart");

        // Back-to-back with fetch_req held high across both requests.
        @(negedge clk); #1;
        clear_all();
        add_exp(2'b01, 1, 32'h0000_0600, 32'h0);
        add_exp(2'b01, 3, 32'h0000_0700, 32'h0);
        lf.fetch_cmd = 2'b01; lf.fetch_tag = 2'd1; lf.fetch_addr = 32'h0000_0600;
        lf.evict_addr = 32'h0; lf.fetch_req = 1'b1;
        hs = cyc;
        chk("b2b first grant", lf.fetch_gnt, 1);
        @(posedge clk); #1;
        lf.fetch_tag = 2'd3; lf.fetch_addr = 32'h0000_0700;
        t = 0;
        @(negedge clk); #1;
        while (!lf.fetch_gnt && t < 500) begin @(negedge clk); #1; t++; end
        hs2 = cyc;
        chk("b2b first latency", done_cyc - hs, 65);
        chk("b2b second grant after done", hs2, done_cyc + 1);
        @(posedge clk); #1;
        lf.fetch_req = 1'b0;
        wait_done(2);
        chk("b2b done_cnt", done_cnt, 2);
        chk("b2b second latency", done_cyc - hs2, 65);
        check_logs("b2b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
- Cache line fetch engine that sits directly downstream of the read controller's fetch port.
- Accepts one fetch request at a time and performs the line transfer for that request, then pulses fetch_done:
  - command 2'b01: fill the allocated line from backing memory into the cache data array.
  - command 2'b10: first write the victim line back to backing memory, then fill.
- Moves one word at a time over a simple request/grant backing-memory bus and the cache data memory read and write ports.

Parameters:
addr_width, 32, word-address width
list_depth, 4, number of cache lines (tag width = $clog2(list_depth))
data_width, 32, word width
list_width, 32, words per line (offset width = $clog2(list_width)); power of two, >= 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  fetch request, held until granted
fetch_gnt  output  1  fetch grant; the handshake completes when fetch_req && fetch_gnt
fetch_cmd  input  2  01 fill, 10 writeback then fill, 00 no-op, 11 treated as 01
fetch_tag  input  $clog2(list_depth)  target line index in the data array
fetch_addr  input  addr_width  line-aligned fill address
evict_addr  input  addr_width  line-aligned victim address, used only for cmd 10
fetch_done  output  1  one-cycle completion pulse
mem_ren  output  1  data-array read request
mem_raddr  output  $clog2(list_depth)+$clog2(list_width)  {tag, word offset}
mem_rready  input  1  read request accepted
mem_rdata  input  data_width  read data
mem_rdata_valid  input  1  read data valid
mem_wen  output  1  data-array write request
mem_waddr  output  $clog2(list_depth)+$clog2(list_width)  {tag, word offset}
mem_wdata  output  data_width  write data
mem_wready  input  1  write accepted
bus_req  output  1  backing-memory request
bus_we  output  1  1 = write, 0 = read
bus_addr  output  addr_width  word address
bus_wdata  output  data_width  write data
bus_gnt  input  1  request accepted
bus_rvalid  input  1  read response valid
bus_rdata  input  data_width  read response data

Behaviour:
- Reset is asynchronous. While rst_n is low, or after it is released:
  - state = IDLE and all counters and captured registers = 0.
  - All outputs = 0, except fetch_gnt = 1 (it follows IDLE).
  - Asserting reset mid-transfer abandons the transfer. No fetch_done is issued.
- fetch_gnt = (state == IDLE). On the handshake, capture cmd, tag, fetch_addr and evict_addr, and clear word counter k.
- Word address for word k = {line_addr[addr_width-1:$clog2(list_width)], k}. k is $clog2(list_width) bits. The last word is k == list_width-1.
- State machine:
  - IDLE: on handshake, cmd 10 -> WB_RD; cmd 00 -> DONE; otherwise -> FL_REQ.
  - WB_RD: mem_ren = 1, mem_raddr = {tag, k}. When mem_rready -> WB_WAIT.
  - WB_WAIT: when mem_rdata_valid, capture the word -> WB_WR. If mem_rdata_valid arrives in the same cycle as mem_rready, WB_WAIT is skipped and the word is captured directly.
  - WB_WR: bus_req = 1, bus_we = 1, bus_addr = evict word k, bus_wdata = captured word. When bus_gnt: if last word, clear k and go to FL_REQ; otherwise increment k and go to WB_RD.
  - FL_REQ: bus_req = 1, bus_we = 0, bus_addr = fill word k. When bus_gnt -> FL_WAIT.
  - FL_WAIT: when bus_rvalid, capture bus_rdata -> FL_WR. If bus_rvalid arrives in the same cycle as bus_gnt, FL_WAIT is skipped.
  - FL_WR: mem_wen = 1, mem_waddr = {tag, k}, mem_wdata = captured word. When mem_wready: if last word go to DONE, otherwise increment k and go to FL_REQ.
  - DONE: fetch_done = 1 for exactly one cycle, then go to IDLE. fetch_gnt is 0 in DONE, so a new request is accepted no earlier than the next cycle.
- At most one outstanding bus read and one outstanding data-array read at any time.
- Request outputs hold their address and data stable until accepted.
- bus_rvalid or mem_rdata_valid outside a wait state is ignored.
- A completed fill followed by a fetch to the same tag is legal. No ordering check is made against the read controller.
- Latency with zero-wait responders:
  - cmd 01: 2*list_width + 1 cycles from handshake to fetch_done.
  - cmd 10: 4*list_width + 1 cycles from handshake to fetch_done.

Decomposition:
- Shared package cache_pkg holds:
  - the fetch_cmd enum (FETCH_NOP = 00, FETCH_FILL = 01, FETCH_WB_FILL = 10);
  - the fill state enum lf_state_t;
  - helper localparams for tag width and offset width.
- Single module; no sub-module.

Test Plan:
- cmd 01, tag 2, fetch_addr 0x100, list_width 32, all readies tied 1, bus_rdata = address -> 32 bus reads at 0x100..0x11F; mem writes at waddr 64..95 with data 0x100..0x11F; fetch_done pulses once, 65 cycles after the handshake.
- cmd 10, tag 1, evict_addr 0x200, fetch_addr 0x300 -> 32 mem reads at raddr 32..63 and bus writes to 0x200..0x21F complete before the first bus read at 0x300; then 32 fills; one fetch_done.
- Random 0–5-cycle stalls on bus_gnt, bus_rvalid, mem_rready and mem_wready -> identical data and address sequence; outputs stable while stalled; no duplicated or missing word.
- cmd 00 -> no bus or mem activity; fetch_done 1 cycle after the handshake; fetch_gnt low exactly one cycle.
- rst_n asserted at word 10 of a fill -> all outputs 0 immediately (fetch_gnt 1 after release); no fetch_done; the next request restarts at k = 0.
- Back-to-back requests with fetch_req held high -> second grant in the cycle after fetch_done; captured tag and address come from the second request.
